sigmoid_backprop: RTL and testbench
===================================

# sigmoid_backprop

Backward-pass engine for one sigmoid neuron. It takes the error at the neuron output (dE/da), the activation, the inputs and the current weight/bias. It computes the sigmoid delta, the error propagated to the previous layer, and the gradient-descent updated weight/bias. It then issues a one-cycle write pulse whose `o_w`/`o_b`/`o_wr` connect directly to the forward neuron's `i_w`/`i_b`/`wr`. A single shared fixed-point multiplier is time-multiplexed by a small FSM.

## Interface
- NUM, 3, number of neuron inputs/weights
- WIDTH, 32, signed fixed-point word width
- FRAC, 24, fraction bits (1.0 = 1<<FRAC)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  request an update; accepted only in IDLE
- i_err  in  WIDTH  dE/da at neuron output
- i_a  in  WIDTH  neuron activation (sigmoid output)
- i_k  in  NUM*WIDTH  neuron inputs, element j at [j*WIDTH +: WIDTH]
- i_w  in  NUM*WIDTH  current weights, same packing
- i_b  in  WIDTH  current bias
- i_lr  in  WIDTH  learning rate
- o_w  out  NUM*WIDTH  updated weights
- o_b  out  WIDTH  updated bias
- o_wr  out  1  one-cycle write strobe to neuron
- o_delta  out  WIDTH  neuron delta
- o_dk  out  NUM*WIDTH  propagated error per input, delta*w_j (old w)
- o_busy  out  1  high in every non-IDLE state
- o_done  out  1  one-cycle completion pulse, coincident with o_wr

## Operation
- All inputs are latched on the edge that accepts i_start. Later input changes have no effect.
- FSM: IDLE → DERIV → DELTA → SCALE → GRAD (2*NUM cycles, index j=0..NUM-1, two sub-steps) → BIAS → WRITE → IDLE.
- DERIV: d = a*(ONE − a).
- DELTA: delta = err*d, registered into o_delta.
- SCALE: g = lr*delta.
- GRAD sub-step 0: w_j' = w_j − g*k_j. Sub-step 1: dk_j = delta*w_j, using the latched old w_j.
- BIAS: b' = b − g.
- WRITE: o_w/o_b are already holding the new values. o_wr=1, o_done=1.
- Multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC, then reduced to WIDTH (see Configuration). Subtractions use the same reduction.
- i_start while busy is ignored, not queued.
- o_w/o_b/o_dk/o_delta hold their values until overwritten by the next update.
- Reset values: state IDLE; o_w, o_b, o_delta, o_dk = 0; o_wr, o_done, o_busy = 0.
- rst asserted mid-operation: at the next edge return to IDLE with all outputs zero. No o_wr is issued.

## Timing
- Accept edge t0: state is DERIV during [t0, t0+1].
- GRAD occupies [t0+3, t0+3+2*NUM].
- WRITE occupies [t0+4+2*NUM, t0+5+2*NUM]. For NUM=3, o_wr/o_done are high from t0+10 to t0+11.
- Back in IDLE at t0+5+2*NUM. A new i_start is accepted on that same edge if high, giving a back-to-back period of 2*NUM+5 cycles.
- o_busy rises at t0 and falls at t0+5+2*NUM.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- BACKPROP_SAT_EN defined: every product and subtraction result that overflows WIDTH clamps to 0x7FF…F or 0x800…0.
- BACKPROP_SAT_EN undefined: results are truncated to the low WIDTH bits, giving two's-complement wrap.
- Cycle timing is identical in both builds.

## Structure
- Shared package bp_pkg holds:
  - the FSM state encoding
  - default WIDTH/FRAC
  - the ONE constant
  - saturation limit constants
- One sub-module, fxp_mul: signed WIDTH×WIDTH multiply, shift by FRAC, and the BACKPROP_SAT_EN-controlled reduction. It is instantiated once and muxed by the FSM.

## Test plan
All values use FRAC=24, NUM=3.
- **Nominal update:** a=0x00800000, err=0x01000000, lr=0x00800000, k={0x01000000, 0x02000000, 0xFF000000}, w={0x00800000 ×3}, b=0.
  - Expect o_delta=0x00400000.
  - Expect o_w={0x00600000, 0x00400000, 0x00A00000} and o_b=0xFFE00000.
  - Expect o_dk={0x00200000 ×3}.
  - Expect o_wr/o_done pulse exactly at t0+10.
- **Busy ignore:** hold i_start high for 12 cycles → exactly two o_done pulses, 11 cycles apart. Change i_k mid-operation → no effect on results.
- **Saturation:** err=0xFF000000, a=0x00800000, lr=0x01000000, k_0=0x7F000000, w_0=0x7FFFFF00.
  - With BACKPROP_SAT_EN: o_w[0]=0x7FFFFFFF.
  - Without BACKPROP_SAT_EN: o_w[0] is the wrapped negative value.
- **Reset mid-op:** assert rst at t0+5 → next edge o_busy=0 and all outputs zero. No o_wr pulse ever appears.
- **Zero error:** err=0 → o_delta=0, o_dk=0, o_w/o_b equal to inputs, o_wr still pulses.
- **Saturated activation:** a=0x01000000 → derivative 0, weights unchanged.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the sigmoid backward-pass engine: FSM encoding,
// default fixed-point format and the constants derived from it.
package bp_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_FRAC  = 24;

  // 1.0 and the saturation limits in the default format
  localparam logic [DEF_WIDTH-1:0] ONE     = DEF_WIDTH'(1) << DEF_FRAC;
  localparam logic [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
  localparam logic [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DERIV = 3'd1,
    S_DELTA = 3'd2,
    S_SCALE = 3'd3,
    S_GRAD  = 3'd4,
    S_BIAS  = 3'd5,
    S_WRITE = 3'd6
  } state_t;

endpackage

// File: rtl/fxp_mul.sv
// Shared signed fixed-point multiply/subtract unit.
// prod_c = reduce((a * b') >>> FRAC), where b' = cmpl ? reduce(1.0 - b) : b
// diff_c = reduce(c - prod_c)
// BACKPROP_SAT_EN defined: reduce clamps to the WIDTH range; otherwise it
// keeps the low WIDTH bits (two's-complement wrap).
module fxp_mul
  import bp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             cmpl,
  output logic [WIDTH-1:0] prod_c,
  output logic [WIDTH-1:0] diff_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  // Signed subtraction with width reduction
  function automatic logic [WIDTH-1:0] sub_red(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
`ifdef BACKPROP_SAT_EN
    logic [WIDTH:0] s;
    s = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
`else
    return x - y;
`endif
  endfunction

  // Full-precision signed product, arithmetic shift by FRAC, width reduction
  function automatic logic [WIDTH-1:0] mul_red(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y);
`ifdef BACKPROP_SAT_EN
    logic signed [PW-1:0] p;
    p = (PW'(x) * PW'(y)) >>> FRAC;
    if (p[PW-1:WIDTH-1] != {(WIDTH+1){p[PW-1]}})
      return p[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return p[WIDTH-1:0];
`else
    return WIDTH'((PW'(x) * PW'(y)) >>> FRAC);
`endif
  endfunction

  logic [WIDTH-1:0] b_eff;

  // Optional (1.0 - b) operand, product, then dependent subtraction
  always_comb begin
    b_eff  = cmpl ? sub_red(ONE_W, b) : b;
    prod_c = mul_red(a, b_eff);
    diff_c = sub_red(c, prod_c);
  end

endmodule

// File: rtl/sigmoid_backprop.sv
// Backward pass for one sigmoid neuron: delta, propagated error and
// gradient-descent weight/bias update through one shared fxp_mul.
// Optional build macro: BACKPROP_SAT_EN (saturating arithmetic).
module sigmoid_backprop
  import bp_pkg::*;
#(
  parameter int unsigned NUM   = 3,
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [WIDTH-1:0]       i_err,
  input  logic [WIDTH-1:0]       i_a,
  input  logic [NUM*WIDTH-1:0]   i_k,
  input  logic [NUM*WIDTH-1:0]   i_w,
  input  logic [WIDTH-1:0]       i_b,
  input  logic [WIDTH-1:0]       i_lr,
  output logic [NUM*WIDTH-1:0]   o_w,
  output logic [WIDTH-1:0]       o_b,
  output logic                   o_wr,
  output logic [WIDTH-1:0]       o_delta,
  output logic [NUM*WIDTH-1:0]   o_dk,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned VW = NUM * WIDTH;
  localparam int unsigned IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  state_t state, state_nxt;

  logic [WIDTH-1:0] err_q, a_q, b_q, lr_q, d_q, g_q;
  logic [VW-1:0]    k_q, w_q;
  logic [IW-1:0]    idx_q;
  logic             sub_q;

  logic [WIDTH-1:0] mul_a, mul_b, mul_c;
  logic             mul_cmpl;
  logic [WIDTH-1:0] prod_c, diff_c;

  fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .c      (mul_c),
    .cmpl   (mul_cmpl),
    .prod_c (prod_c),
    .diff_c (diff_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and multiplier operand selection
  always_comb begin
    state_nxt = state;
    mul_a     = '0;
    mul_b     = '0;
    mul_c     = '0;
    mul_cmpl  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_nxt = S_DERIV;
      end
      S_DERIV: begin
        mul_a     = a_q;
        mul_b     = a_q;
        mul_cmpl  = 1'b1;
        state_nxt = S_DELTA;
      end
      S_DELTA: begin
        mul_a     = err_q;
        mul_b     = d_q;
        state_nxt = S_SCALE;
      end
      S_SCALE: begin
        mul_a     = lr_q;
        mul_b     = o_delta;
        state_nxt = S_GRAD;
      end
      S_GRAD: begin
        if (!sub_q) begin
          mul_a = g_q;
          mul_b = k_q[idx_q*WIDTH +: WIDTH];
          mul_c = w_q[idx_q*WIDTH +: WIDTH];
        end else begin
          mul_a = o_delta;
          mul_b = w_q[idx_q*WIDTH +: WIDTH];
        end
        if (sub_q && (idx_q == IW'(NUM-1))) state_nxt = S_BIAS;
      end
      S_BIAS: begin
        mul_a     = g_q;
        mul_b     = ONE_W;
        mul_c     = b_q;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = i_start ? S_DERIV : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Input capture, per-state result registers and status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lr_q    <= '0;
      d_q     <= '0;
      g_q     <= '0;
      k_q     <= '0;
      w_q     <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      o_w     <= '0;
      o_b     <= '0;
      o_dk    <= '0;
      o_delta <= '0;
      o_wr    <= 1'b0;
      o_done  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WRITE: begin
          if (state_nxt == S_DERIV) begin
            err_q <= i_err;
            a_q   <= i_a;
            b_q   <= i_b;
            lr_q  <= i_lr;
            k_q   <= i_k;
            w_q   <= i_w;
            idx_q <= '0;
            sub_q <= 1'b0;
          end
        end
        S_DERIV: d_q     <= prod_c;
        S_DELTA: o_delta <= prod_c;
        S_SCALE: g_q     <= prod_c;
        S_GRAD: begin
          if (!sub_q) begin
            o_w[idx_q*WIDTH +: WIDTH] <= diff_c;
          end else begin
            o_dk[idx_q*WIDTH +: WIDTH] <= prod_c;
            idx_q <= idx_q + IW'(1);
          end
          sub_q <= ~sub_q;
        end
        S_BIAS:  o_b <= diff_c;
        default: ;
      endcase
      o_busy <= (state_nxt != S_IDLE);
      o_wr   <= (state_nxt == S_WRITE);
      o_done <= (state_nxt == S_WRITE);
    end
  end

endmodule

// File: tb/tb_sigmoid_backprop.sv
// Bench for sigmoid_backprop: behavioural model plus directed literal cases.
module tb_sigmoid_backprop;

  localparam int NUM = 3;
  localparam int W   = 32;
  localparam int F   = 24;
  localparam int ONE = 32'h01000000;
  localparam int WR_AGE = 4 + 2*NUM;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start;
  logic [W-1:0]       i_err, i_a, i_b, i_lr;
  logic [NUM*W-1:0]   i_k, i_w;
  logic [NUM*W-1:0]   o_w, o_dk;
  logic [W-1:0]       o_b, o_delta;
  logic               o_wr, o_busy, o_done;

  sigmoid_backprop dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_err(i_err), .i_a(i_a),
    .i_k(i_k), .i_w(i_w), .i_b(i_b), .i_lr(i_lr), .o_w(o_w), .o_b(o_b),
    .o_wr(o_wr), .o_delta(o_delta), .o_dk(o_dk), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [NUM*W-1:0] act, input logic [NUM*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural arithmetic model ----------------
  function automatic int red(input longint v);
`ifdef BACKPROP_SAT_EN
    if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (v < -64'sd2147483648) return 32'h80000000;
`endif
    return int'(v);
  endfunction

  function automatic int fmul(input int x, input int y);
    return red((longint'(x) * longint'(y)) >>> F);
  endfunction

  function automatic int fsub(input int x, input int y);
    return red(longint'(x) - longint'(y));
  endfunction

  int               m_age = -1;
  logic             exp_wr = 1'b0;
  logic [W-1:0]     exp_delta = '0, exp_b = '0, r_delta, r_b;
  logic [NUM*W-1:0] exp_w = '0, exp_dk = '0, r_w, r_dk;

  // Model: accept when idle (or on the write cycle), results appear at fixed ages
  always @(posedge clk) begin
    int d, g, kj, wj;
    if (rst) begin
      m_age = -1; exp_wr = 1'b0;
      exp_delta = '0; exp_b = '0; exp_w = '0; exp_dk = '0;
    end else begin
      if (m_age >= 0) m_age++;
      if (m_age == 2) exp_delta = r_delta;
      if (m_age == WR_AGE) begin
        exp_w = r_w; exp_dk = r_dk; exp_b = r_b; exp_wr = 1'b1;
      end
      if (m_age == WR_AGE + 1) begin
        exp_wr = 1'b0; m_age = -1;
      end
      if (m_age < 0 && i_start) begin
        d       = fmul(int'(i_a), fsub(ONE, int'(i_a)));
        r_delta = fmul(int'(i_err), d);
        g       = fmul(int'(i_lr), int'(r_delta));
        for (int j = 0; j < NUM; j++) begin
          kj = int'(i_k[j*W +: W]);
          wj = int'(i_w[j*W +: W]);
          r_w[j*W +: W]  = fsub(wj, fmul(g, kj));
          r_dk[j*W +: W] = fmul(int'(r_delta), wj);
        end
        r_b   = fsub(int'(i_b), g);
        m_age = 0;
      end
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", o_busy, m_age >= 0);
      chk("wr", o_wr, exp_wr);
      chk("done", o_done, exp_wr);
      chk("delta", o_delta, exp_delta);
      if (m_age < 4 || m_age >= WR_AGE) begin
        chk("w", o_w, exp_w);
        chk("b", o_b, exp_b);
        chk("dk", o_dk, exp_dk);
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int t0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string nm, output int tdone);
    tdone = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (o_done) begin
        tdone = cyc;
        break;
      end
    end
    if (tdone < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for o_done got 0 want 1", nm);
    end
  endtask

  task automatic set_nominal();
    i_a   = 32'h00800000;
    i_err = 32'h01000000;
    i_lr  = 32'h00800000;
    i_k   = {32'hFF000000, 32'h02000000, 32'h01000000};
    i_w   = {3{32'h00800000}};
    i_b   = 32'h0;
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom % 4)
      0:       return $urandom;
      1:       return $urandom_range(0, ONE);
      default: return W'($urandom_range(0, 32'h08000000)) - 32'h04000000;
    endcase
  endfunction

  task automatic randomize_inputs();
    i_err = rnd_word();
    i_a   = rnd_word();
    i_b   = rnd_word();
    i_lr  = rnd_word();
    for (int j = 0; j < NUM; j++) begin
      i_k[j*W +: W] = rnd_word();
      i_w[j*W +: W] = rnd_word();
    end
  endtask

  localparam logic [NUM*W-1:0] NOM_W  = {32'h00A00000, 32'h00400000, 32'h00600000};
  localparam logic [NUM*W-1:0] NOM_DK = {3{32'h00200000}};

  initial begin
    int t0, td, ndone, first, second;
    logic saw_wr;
    rst = 1'b1; i_start = 1'b0;
    i_err = '0; i_a = '0; i_b = '0; i_lr = '0; i_k = '0; i_w = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_w", o_w, 0);
    chk("rst_dk", o_dk, 0);
    chk("rst_wr", {o_wr, o_done}, 0);

    // Nominal update with literal expectations and latency
    set_nominal();
    pulse_start(t0);
    wait_done("nominal", td);
    chk("nom_latency", td - t0, 10);
    chk("nom_wr", o_wr, 1);
    chk("nom_delta", o_delta, 32'h00400000);
    chk("nom_w", o_w, NOM_W);
    chk("nom_b", o_b, 32'hFFE00000);
    chk("nom_dk", o_dk, NOM_DK);
    chk("model_delta", exp_delta, 32'h00400000);
    chk("model_w", exp_w, NOM_W);
    tick();
    chk("nom_done_one_cycle", o_done, 0);
    tick();

    // start held 12 cycles, inputs changed mid-operation
    set_nominal();
    ndone = 0; first = -1; second = -1;
    i_start = 1'b1;
    for (int n = 0; n < 32; n++) begin
      tick();
      if (n == 0) t0 = cyc;
      if (n == 2) i_k = {32'h12345678, 32'h40000000, 32'hC0000000};
      if (n == 11) i_start = 1'b0;
      if (o_done) begin
        ndone++;
        if (first < 0) begin
          first = cyc;
          chk("hold_first_w", o_w, NOM_W);
        end else second = cyc;
      end
    end
    chk("hold_ndone", ndone, 2);
    chk("hold_first_at", first - t0, 10);
    chk("hold_spacing", second - first, 11);

    // Saturation / wrap on w_0
    i_err = 32'hFF000000; i_a = 32'h00800000; i_lr = 32'h01000000; i_b = '0;
    i_k = {32'h0, 32'h0, 32'h7F000000};
    i_w = {32'h0, 32'h0, 32'h7FFFFF00};
    pulse_start(t0);
    wait_done("sat", td);
`ifdef BACKPROP_SAT_EN
    chk("sat_w0", o_w[W-1:0], 32'h7FFFFFFF);
`else
    chk("wrap_w0", o_w[W-1:0], 32'h9FBFFF00);
`endif
    chk("sat_delta", o_delta, 32'hFFC00000);
    tick();

    // Zero error: weights/bias unchanged, strobe still issued
    set_nominal();
    i_err = '0; i_b = 32'h00123456;
    pulse_start(t0);
    wait_done("zero_err", td);
    chk("zero_delta", o_delta, 0);
    chk("zero_dk", o_dk, 0);
    chk("zero_w", o_w, {3{32'h00800000}});
    chk("zero_b", o_b, 32'h00123456);
    tick();

    // Activation at 1.0: derivative zero
    set_nominal();
    i_a = 32'h01000000; i_b = 32'hFFF00000;
    pulse_start(t0);
    wait_done("sat_act", td);
    chk("satact_delta", o_delta, 0);
    chk("satact_w", o_w, {3{32'h00800000}});
    chk("satact_b", o_b, 32'hFFF00000);
    tick();

    // Reset at t0+5: everything zero, no write strobe afterwards
    set_nominal();
    pulse_start(t0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_w", o_w, 0);
    chk("rstmid_dk", o_dk, 0);
    chk("rstmid_bd", {o_b, o_delta}, 0);
    saw_wr = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (o_wr) saw_wr = 1'b1;
    end
    chk("rstmid_no_wr", saw_wr, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      randomize_inputs();
      i_start = ($urandom % 3) == 0;
      rst     = ($urandom % 151) == 0;
      tick();
    end
    i_start = 1'b0;
    rst = 1'b0;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
